// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation SAD search block.
// Holds the default geometry (block size, pair count, SAD and index widths),
// the search FSM state encoding and the all-ones SAD constant.
package me_pkg;

    localparam int unsigned BLK_PIX_DEF   = 256;
    localparam int unsigned NUM_PAIRS_DEF = 32;
    localparam int unsigned SAD_W_DEF     = 16;
    localparam int unsigned IDX_W_DEF     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

endpackage

// File: rtl/abs_diff_acc.sv
// One SAD lane: 8-bit absolute difference feeding an SAD_W accumulator.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   clr           synchronous clear of the accumulator (search start)
//   en            accept this pixel pair
//   restart       last pixel of a block: accumulator reloads 0 instead of sum
//   a, b          8-bit pixels
//   sum           accumulator plus the current difference (final sum on last pixel)
module abs_diff_acc
    import me_pkg::*;
#(
    parameter int unsigned SAD_W = SAD_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             restart,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [SAD_W-1:0] sum
);

    logic [7:0]       diff;
    logic [SAD_W-1:0] acc_q;

    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
    end

    assign sum = acc_q + SAD_W'(diff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            // Restart on the block's last pixel so the next pair needs no bubble.
            acc_q <= restart ? '0 : sum;
        end
    end

endmodule

// File: rtl/sad_best_match.sv
// Best-match SAD search over NUM_PAIRS candidate pairs of BLK_PIX pixels each.
// Two lanes accumulate |c-p| and |c-p_prime| in parallel; at each block end the
// sums are snapshotted and compared against the running minimum one cycle later.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 single-cycle search start (ignored unless idle)
//   in_valid, c, p, p_prime  pixel triple, accepted while accumulating
//   busy                  search in progress
//   done                  one-cycle pulse, best_sad/best_idx valid
//   best_sad, best_idx    minimum SAD and its candidate index
// Optional (macro SAD_ALL_OUT_EN): sad_out, sad_idx, sad_out_valid stream every
// candidate SAD, two consecutive cycles per pair (even then odd candidate).
module sad_best_match
    import me_pkg::*;
#(
    parameter int unsigned BLK_PIX   = BLK_PIX_DEF,
    parameter int unsigned NUM_PAIRS = NUM_PAIRS_DEF,
    parameter int unsigned SAD_W     = SAD_W_DEF,
    parameter int unsigned IDX_W     = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       c,
    input  logic [7:0]       p,
    input  logic [7:0]       p_prime,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx
`ifdef SAD_ALL_OUT_EN
    ,
    output logic [SAD_W-1:0] sad_out,
    output logic [IDX_W-1:0] sad_idx,
    output logic             sad_out_valid
`endif
);

    localparam int unsigned PIX_W  = $clog2(BLK_PIX);
    localparam int unsigned PAIR_W = IDX_W - 1;
    localparam logic [SAD_W-1:0] SadMax = '1;

    state_t state_q, state_d;

    logic [PIX_W-1:0]  pix_cnt_q;
    logic [PAIR_W-1:0] pair_cnt_q, snap_pair_q;
    logic [SAD_W-1:0]  sum0, sum1, snap0_q, snap1_q, best_sad_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic              snap_vld_q, done_q;
    logic              accept, pix_last, pair_last, start_search, end_pair;
    logic [SAD_W-1:0]  cmp0_sad, cmp1_sad;
    logic [IDX_W-1:0]  cmp0_idx, cmp1_idx;

    assign accept       = (state_q == ACCUM) && in_valid;
    assign pix_last     = (pix_cnt_q == PIX_W'(BLK_PIX - 1));
    assign pair_last    = (pair_cnt_q == PAIR_W'(NUM_PAIRS - 1));
    assign start_search = (state_q == IDLE) && start;
    assign end_pair     = accept && pix_last;

    abs_diff_acc #(.SAD_W(SAD_W)) u_lane0 (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_search),
        .en      (accept),
        .restart (pix_last),
        .a       (c),
        .b       (p),
        .sum     (sum0)
    );

    abs_diff_acc #(.SAD_W(SAD_W)) u_lane1 (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_search),
        .en      (accept),
        .restart (pix_last),
        .a       (c),
        .b       (p_prime),
        .sum     (sum1)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (end_pair && pair_last) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt_q  <= '0;
            pair_cnt_q <= '0;
        end else if (start_search) begin
            pix_cnt_q  <= '0;
            pair_cnt_q <= '0;
        end else if (accept) begin
            // BLK_PIX is a power of two, so the pixel count wraps on its own.
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_last) pair_cnt_q <= pair_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_vld_q  <= 1'b0;
            snap0_q     <= '0;
            snap1_q     <= '0;
            snap_pair_q <= '0;
        end else begin
            snap_vld_q <= end_pair && !start_search;
            if (end_pair) begin
                snap0_q     <= sum0;
                snap1_q     <= sum1;
                snap_pair_q <= pair_cnt_q;
            end
        end
    end

    // Even candidate first, then odd against the updated best; strict < keeps
    // the lower index on ties.
    always_comb begin
        cmp0_sad = best_sad_q;
        cmp0_idx = best_idx_q;
        if (snap0_q < best_sad_q) begin
            cmp0_sad = snap0_q;
            cmp0_idx = {snap_pair_q, 1'b0};
        end
        cmp1_sad = cmp0_sad;
        cmp1_idx = cmp0_idx;
        if (snap1_q < cmp0_sad) begin
            cmp1_sad = snap1_q;
            cmp1_idx = {snap_pair_q, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_sad_q <= SadMax;
            best_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            // The final pair's compare lands on the same edge as leaving FINAL.
            done_q <= (state_q == FINAL);
            if (start_search) begin
                best_sad_q <= SadMax;
                best_idx_q <= '0;
            end else if (snap_vld_q) begin
                best_sad_q <= cmp1_sad;
                best_idx_q <= cmp1_idx;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign best_sad = best_sad_q;
    assign best_idx = best_idx_q;

`ifdef SAD_ALL_OUT_EN
    logic [SAD_W-1:0] skid_q;
    logic [IDX_W-1:0] skid_idx_q;
    logic             skid_vld_q;

    // snap1 waits one cycle here while snap0 is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_q     <= '0;
            skid_idx_q <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_vld_q <= snap_vld_q;
            if (snap_vld_q) begin
                skid_q     <= snap1_q;
                skid_idx_q <= {snap_pair_q, 1'b1};
            end
        end
    end

    assign sad_out_valid = snap_vld_q | skid_vld_q;
    assign sad_out       = snap_vld_q ? snap0_q : skid_q;
    assign sad_idx       = snap_vld_q ? {snap_pair_q, 1'b0} : skid_idx_q;
`endif

endmodule

// File: tb/tb_sad_best_match.sv
// Scoreboard bench for sad_best_match: the driver pushes hand-computed results,
// a negedge monitor pops and compares whenever done (or sad_out_valid) is seen.
module tb_sad_best_match;
    import me_pkg::*;

    localparam int BLK = 256;
    localparam int NP  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  c = '0, p = '0, p_prime = '0;
    logic        busy, done;
    logic [15:0] best_sad;
    logic [5:0]  best_idx;
`ifdef SAD_ALL_OUT_EN
    logic [15:0] sad_out;
    logic [5:0]  sad_idx;
    logic        sad_out_valid;
`endif

    sad_best_match dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .c        (c),
        .p        (p),
        .p_prime  (p_prime),
        .busy     (busy),
        .done     (done),
        .best_sad (best_sad),
        .best_idx (best_idx)
`ifdef SAD_ALL_OUT_EN
        ,
        .sad_out       (sad_out),
        .sad_idx       (sad_idx),
        .sad_out_valid (sad_out_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int sad;
        int idx;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   cand_q[$];
    exp_t   e, ce;
    int     checks = 0;
    int     failures = 0;
    int     done_count = 0;
    logic   prev_done = 1'b0;
    longint last_acc_time = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Directed pixel patterns per scenario.
    function automatic void pix(input int scen, input int pr, input int px,
                                output logic [7:0] cv, output logic [7:0] pv,
                                output logic [7:0] ppv);
        int lim;
        cv = 8'd0; pv = 8'd0; ppv = 8'd0;
        case (scen)
            1: begin cv = 8'h40; pv = 8'h40; ppv = 8'h40; end
            2, 5: begin cv = 8'd10; ppv = (pr == 2) ? 8'd10 : 8'd0; end
            3: cv = 8'd255;
            default: begin
                lim = ((2 * pr + 1) == 3 || (2 * pr + 1) == 7) ? 100 : 200;
                pv  = (px < 200) ? 8'd1 : 8'd0;
                ppv = (px < lim) ? 8'd1 : 8'd0;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_one_cycle", longint'(done), 0);
            if (done) begin
                done_count++;
                check("done_latency", longint'($time) - last_acc_time, 14);
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("best_sad", longint'(best_sad), e.sad);
                    check("best_idx", longint'(best_idx), e.idx);
                end
            end
            prev_done = done;
`ifdef SAD_ALL_OUT_EN
            if (sad_out_valid) begin
                if (cand_q.size() == 0) begin
                    check("sad_out_unexpected", 1, 0);
                end else begin
                    ce = cand_q.pop_front();
                    check("sad_out", longint'(sad_out), ce.sad);
                    check("sad_idx", longint'(sad_idx), ce.idx);
                end
            end
`endif
        end
    end

    task automatic run_search(input int scen, input int gap_pct, input int abort_pair,
                              input int exp_sad, input int exp_idx);
        logic [7:0] cv, pv, ppv;
        int a0, a1, busy_bad, dc0, n;
        busy_bad = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int pr = 0; pr < NP; pr++) begin
            a0 = 0;
            a1 = 0;
            for (int px = 0; px < BLK; px++) begin
                while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    in_valid = 1'b0;
                    c = 8'($urandom); p = 8'($urandom); p_prime = 8'($urandom);
                    start = ($urandom_range(99) < 2);
                    @(posedge clk); #1;
                    start = 1'b0;
                    if (!busy) busy_bad++;
                end
                if (pr == abort_pair && px == 5) begin
                    in_valid = 1'b0;
                    reset = 1'b1;
                    #2;
                    check("abort_busy", longint'(busy), 0);
                    check("abort_done", longint'(done), 0);
                    check("abort_best_sad", longint'(best_sad), longint'(SAD_MAX));
                    check("abort_best_idx", longint'(best_idx), 0);
                    @(negedge clk);
                    reset = 1'b0;
                    @(posedge clk); #1;
                    return;
                end
                pix(scen, pr, px, cv, pv, ppv);
                c = cv; p = pv; p_prime = ppv;
                in_valid = 1'b1;
                start = (gap_pct > 0 && pr == 15 && px == 0);
                a0 += (cv >= pv) ? int'(cv - pv) : int'(pv - cv);
                a1 += (cv >= ppv) ? int'(cv - ppv) : int'(ppv - cv);
`ifdef SAD_ALL_OUT_EN
                if (px == BLK - 1) begin
                    cand_q.push_back('{a0, 2 * pr});
                    cand_q.push_back('{a1, 2 * pr + 1});
                end
`endif
                if (pr == NP - 1 && px == BLK - 1) exp_q.push_back('{exp_sad, exp_idx});
                dc0 = done_count;
                @(posedge clk); #1;
                start = 1'b0;
                if (!busy) busy_bad++;
            end
        end
        last_acc_time = longint'($time);
        in_valid = 1'b0;
        check("busy_during_search", busy_bad, 0);
        n = 0;
        while (done_count == dc0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", done_count - dc0, 1);
        check("busy_after_done", longint'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_best_sad", longint'(best_sad), exp_sad);
        check("hold_best_idx", longint'(best_idx), exp_idx);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_best_sad", longint'(best_sad), 65535);
        check("reset_best_idx", longint'(best_idx), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_search(1, 0, -1, 0, 0);
        run_search(2, 0, -1, 0, 5);
        run_search(3, 0, -1, 65280, 0);
        run_search(4, 0, -1, 100, 3);
        run_search(5, 30, -1, 0, 5);
        run_search(6, 0, 10, 0, 0);
`ifdef SAD_ALL_OUT_EN
        cand_q.delete();
`endif
        run_search(6, 0, -1, 100, 3);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
`ifdef SAD_ALL_OUT_EN
        check("cand_scoreboard_empty", cand_q.size(), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
